memory_arbiter: RTL and testbench



---
 rtl/interface_pkg.sv | 24 ++
 rtl/memory_arbiter_pkg.sv | 12 +
 rtl/memory_arbiter_rr_picker.sv | 28 ++
 rtl/memory_arbiter.sv | 108 ++++++++++
 tb/tb_memory_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/interface_pkg.sv
// Memory request/response structs shared by the caches, the arbiter and Memory,
// plus the memory latency constant used by benches.
package interface_pkg;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  strobe;
    } Memory_Request;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } Memory_Response;

endpackage

package memory_pkg;

    localparam int unsigned DELAY = 4;

endpackage

// File: rtl/memory_arbiter_pkg.sv
// Arbiter FSM encoding, default port count and the round-robin pointer helper.
package arbiter_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;

    localparam int unsigned DEFAULT_NUM_REQ = 2;

    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin find-first: first set bit of i_valid at or after
// i_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_idx       = '0;
        o_any_valid = 1'b0;
        w_cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_any_valid && i_valid[w_cand]) begin
                o_any_valid = 1'b1;
                o_idx       = w_cand;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin sequencer sharing one Memory port between NUM_REQ requesters.
// Optional per-port performance counters are enabled with `define MEM_ARB_PERF_EN.
module memory_arbiter
    import interface_pkg::*;
    import arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  Memory_Request    ReqIn   [NUM_REQ],
    output Memory_Response   RespOut [NUM_REQ],
    output Memory_Request    MemoryRequest,
    input  Memory_Response   MemoryResponse,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]      grant_cnt [NUM_REQ],
    output logic [31:0]      wait_cnt  [NUM_REQ]
`endif
);

    arb_state_t       r_state, w_next_state;
    logic [IDX_W-1:0] r_rr_ptr, r_grant_idx, w_pick_idx;
    logic [NUM_REQ-1:0] w_valid;
    logic             w_any_valid;

    always_comb begin
        w_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) w_valid[i] = ReqIn[i].valid;
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_valid     (w_valid),
        .i_ptr       (r_rr_ptr),
        .o_idx       (w_pick_idx),
        .o_any_valid (w_any_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_any_valid) r_grant_idx <= w_pick_idx;
            if (r_state == RELEASE) r_rr_ptr <= IDX_W'(next_rr(32'(r_grant_idx), NUM_REQ));
        end
    end

    // Response data is broadcast; only the owner's valid is forwarded in BUSY.
    always_comb begin
        w_next_state        = r_state;
        MemoryRequest       = ReqIn[r_grant_idx];
        MemoryRequest.valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            RespOut[i].valid = 1'b0;
            RespOut[i].data  = MemoryResponse.data;
        end
        case (r_state)
            IDLE: if (w_any_valid) w_next_state = BUSY;
            BUSY: begin
                MemoryRequest                = ReqIn[r_grant_idx];
                RespOut[r_grant_idx].valid   = MemoryResponse.valid;
                if (MemoryResponse.valid) w_next_state = RELEASE;
            end
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign grant_idx = r_grant_idx;
    assign busy      = (r_state != IDLE);

    a_owner_holds_valid: assert property (@(posedge clk) disable iff (rst)
        (r_state == BUSY) |-> ReqIn[r_grant_idx].valid);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_grant_cnt [NUM_REQ];
    logic [31:0] r_wait_cnt  [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                r_grant_cnt[i] <= '0;
                r_wait_cnt[i]  <= '0;
            end else begin
                if (r_state == BUSY && w_next_state == RELEASE &&
                    r_grant_idx == IDX_W'(i) && r_grant_cnt[i] != '1)
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
                if (ReqIn[i].valid && !(r_state == BUSY && r_grant_idx == IDX_W'(i)) &&
                    r_wait_cnt[i] != '1)
                    r_wait_cnt[i] <= r_wait_cnt[i] + 32'd1;
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign wait_cnt  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter with a behavioural Memory model and per-port
// expected-response queues; define MEM_ARB_PERF_EN to also check the counters.
module tb_memory_arbiter;
    import interface_pkg::*;
    import memory_pkg::*;

    localparam int unsigned NREQ = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    Memory_Request  ReqIn   [NREQ];
    Memory_Response RespOut [NREQ];
    Memory_Request  MemoryRequest;
    Memory_Response MemoryResponse;
    logic [0:0]     grant_idx;
    logic           busy;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]    grant_cnt [NREQ];
    logic [31:0]    wait_cnt  [NREQ];
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          grant_log[$];
    int          resp_cyc[$];
    int          cycle     = 0;
    int          wait_meas = 0;
    logic        prev_busy = 1'b0;

    logic [31:0] ram [256];
    int          mcnt;

    typedef struct {
        int          port;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    memory_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .ReqIn          (ReqIn),
        .RespOut        (RespOut),
        .MemoryRequest  (MemoryRequest),
        .MemoryResponse (MemoryResponse),
        .grant_idx      (grant_idx),
        .busy           (busy)
`ifdef MEM_ARB_PERF_EN
        ,
        .grant_cnt      (grant_cnt),
        .wait_cnt       (wait_cnt)
`endif
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Memory model: responds DELAY edges after a request, single-cycle pulse.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            ram[16]        <= 32'hDEADBEEF;
            MemoryResponse <= '0;
            mcnt           <= 0;
        end else if (MemoryRequest.valid && !MemoryResponse.valid) begin
            if (mcnt == int'(DELAY) - 1) begin
                mcnt                 <= 0;
                MemoryResponse.valid <= 1'b1;
                if (MemoryRequest.wen) begin
                    ram[MemoryRequest.address[9:2]] <= merge(ram[MemoryRequest.address[9:2]],
                                                             MemoryRequest.data, MemoryRequest.strobe);
                    MemoryResponse.data <= merge(ram[MemoryRequest.address[9:2]],
                                                 MemoryRequest.data, MemoryRequest.strobe);
                end else begin
                    MemoryResponse.data <= ram[MemoryRequest.address[9:2]];
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            MemoryResponse.valid <= 1'b0;
            mcnt                 <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int p, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s, input logic [31:0] e);
        vec_t v;
        v.port = p; v.wen = w; v.addr = a; v.data = d; v.strb = s; v.exp = e;
        return v;
    endfunction

    task automatic monitor();
        logic [31:0] e;
        bit          have;
        forever begin
            @(negedge clk);
            cycle++;
            if (rst) wait_meas = 0;
            else if (ReqIn[1].valid && !(busy && grant_idx == 1'b1)) wait_meas++;
            if (busy && !prev_busy) grant_log.push_back(int'(grant_idx));
            prev_busy = busy;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (RespOut[i].valid === 1'b1) begin
                    resp_cyc.push_back(cycle);
                    check("resp_from_owner", 32'(busy && int'(grant_idx) == i), 32'd1);
                    have = 1'b0;
                    e    = '0;
                    if (i == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
                    if (i == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
                    if (!have) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL resp_unexpected: port %0d actual data=%0h required no response",
                                 i, RespOut[i].data);
                    end else begin
                        check($sformatf("resp_data_p%0d", i), RespOut[i].data, e);
                    end
                end
            end
        end
    endtask

    task automatic do_txn(input int p, input logic wen, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [31:0] exp);
        Memory_Request r;
        bit            got;
        r.valid = 1'b1; r.wen = wen; r.address = addr; r.data = data; r.strobe = strb;
        @(posedge clk); #1;
        ReqIn[p] = r;
        if (p == 0) exp_q0.push_back(exp);
        else        exp_q1.push_back(exp);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = RespOut[p].valid;
        end
        check($sformatf("resp_timeout_p%0d", p), 32'(got), 32'd1);
        @(posedge clk); #1;
        ReqIn[p].valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) ReqIn[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic contention_run();
        fork
            do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
            do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
        join
    endtask

    initial begin
        for (int i = 0; i < int'(NREQ); i++) ReqIn[i] = '0;
        fork monitor(); join_none
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_mreq_valid", 32'(MemoryRequest.valid), 32'd0);
        check("rst_resp0_valid", 32'(RespOut[0].valid), 32'd0);
        check("rst_resp1_valid", 32'(RespOut[1].valid), 32'd0);

        // Single read on port 0, then RELEASE and IDLE.
        do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
        check("release_busy", 32'(busy), 32'd1);
        check("release_mreq_valid", 32'(MemoryRequest.valid), 32'd0);
        check("release_resp0_valid", 32'(RespOut[0].valid), 32'd0);
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        tbl[0] = mk(1, 1'b1, 32'h80, 32'h11223344, 4'b0101, 32'h00220044);
        tbl[1] = mk(0, 1'b0, 32'h80, 32'h0,        4'h0,    32'h00220044);
        tbl[2] = mk(1, 1'b0, 32'h40, 32'h0,        4'h0,    32'hDEADBEEF);
        tbl[3] = mk(0, 1'b1, 32'h44, 32'hCAFEF00D, 4'hF,    32'hCAFEF00D);
        tbl[4] = mk(1, 1'b0, 32'h44, 32'h0,        4'h0,    32'hCAFEF00D);
        tbl[5] = mk(0, 1'b1, 32'h44, 32'hAABBCCDD, 4'b1000, 32'hAAFEF00D);
        tbl[6] = mk(1, 1'b0, 32'h80, 32'h0,        4'h0,    32'h00220044);
        tbl[7] = mk(0, 1'b0, 32'h44, 32'h0,        4'h0,    32'hAAFEF00D);
        for (int t = 0; t < 8; t++)
            do_txn(tbl[t].port, tbl[t].wen, tbl[t].addr, tbl[t].data, tbl[t].strb, tbl[t].exp);

        // Contention straight after reset: port 0 first, then port 1.
        do_reset();
        grant_log.delete();
        resp_cyc.delete();
        contention_run();
        check("cont_grants", 32'(grant_log.size()), 32'd2);
        check("cont_resps", 32'(resp_cyc.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("cont_first", 32'(grant_log[0]), 32'd0);
            check("cont_second", 32'(grant_log[1]), 32'd1);
        end
        if (resp_cyc.size() == 2)
            check("cont_gap_ge3", 32'(resp_cyc[1] - resp_cyc[0] >= 3), 32'd1);

        // Fairness: port 0 re-requests back to back, port 1 once.
        do_reset();
        grant_log.delete();
        fork
            begin
                do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
                do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
            end
            begin
                @(posedge clk);
                do_txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);
            end
        join
        check("fair_grants", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) begin
            check("fair_g0", 32'(grant_log[0]), 32'd0);
            check("fair_g1", 32'(grant_log[1]), 32'd1);
            check("fair_g2", 32'(grant_log[2]), 32'd0);
        end

        // Grant latency, then reset while port 0 waits in BUSY.
        do_reset();
        @(posedge clk); #1;
        ReqIn[0].valid   = 1'b1;
        ReqIn[0].wen     = 1'b0;
        ReqIn[0].address = 32'h40;
        @(negedge clk);
        check("lat_idle_mreq", 32'(MemoryRequest.valid), 32'd0);
        @(negedge clk);
        check("lat_busy_mreq", 32'(MemoryRequest.valid), 32'd1);
        check("lat_busy_addr", MemoryRequest.address, 32'h40);
        check("lat_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst            = 1'b1;
        ReqIn[0].valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mreq", 32'(MemoryRequest.valid), 32'd0);
        repeat (8) @(negedge clk);
        do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF);

`ifdef MEM_ARB_PERF_EN
        do_reset();
        repeat (3) contention_run();
        repeat (3) @(negedge clk);
        check("perf_grant0", grant_cnt[0], 32'd3);
        check("perf_grant1", grant_cnt[1], 32'd3);
        check("perf_wait1", wait_cnt[1], 32'(wait_meas));
`endif

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
